// File: rtl/mips_isa_pkg.sv
// MIPS subset ISA constants shared by the program loader and the control decoder.
// Holds opcode/funct codes, symbolic instruction kinds, loader FSM states and field packing helpers.
package mips_isa_pkg;

  localparam logic [5:0] OP_R   = 6'h00;
  localparam logic [5:0] OP_JAL = 6'h03;
  localparam logic [5:0] OP_BEQ = 6'h04;
  localparam logic [5:0] OP_ORI = 6'h0D;
  localparam logic [5:0] OP_LUI = 6'h0F;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_SW  = 6'h2B;

  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADDU = 6'h20;
  localparam logic [5:0] FN_SUBU = 6'h22;
  localparam logic [5:0] FN_XOR  = 6'h26;

  // Symbolic instruction kinds; codes 11..15 are illegal.
  localparam logic [3:0] KIND_NOP  = 4'd0;
  localparam logic [3:0] KIND_ADDU = 4'd1;
  localparam logic [3:0] KIND_SUBU = 4'd2;
  localparam logic [3:0] KIND_LW   = 4'd3;
  localparam logic [3:0] KIND_SW   = 4'd4;
  localparam logic [3:0] KIND_BEQ  = 4'd5;
  localparam logic [3:0] KIND_LUI  = 4'd6;
  localparam logic [3:0] KIND_ORI  = 4'd7;
  localparam logic [3:0] KIND_JAL  = 4'd8;
  localparam logic [3:0] KIND_JR   = 4'd9;
  localparam logic [3:0] KIND_XOR  = 4'd10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic [31:0] r_type(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [5:0] funct);
    return {OP_R, rs, rt, rd, 5'b0, funct};
  endfunction

  function automatic logic [31:0] i_type(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

endpackage

// File: rtl/instr_encode.sv
// Combinational encoder from a symbolic instruction to its 32-bit MIPS word.
// Fields an instruction format does not use are forced to zero regardless of the inputs.
module instr_encode
  import mips_isa_pkg::*;
(
  input  logic [3:0]  kind,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [15:0] imm,
  input  logic [25:0] target,
  output logic [31:0] word,
  output logic        legal
);

  always_comb begin
    word  = 32'h0000_0000;
    legal = 1'b1;
    case (kind)
      KIND_NOP:  word = 32'h0000_0000;
      KIND_ADDU: word = r_type(rs, rt, rd, FN_ADDU);
      KIND_SUBU: word = r_type(rs, rt, rd, FN_SUBU);
      KIND_XOR:  word = r_type(rs, rt, rd, FN_XOR);
      KIND_JR:   word = {OP_R, rs, 15'b0, FN_JR};
      KIND_LW:   word = i_type(OP_LW, rs, rt, imm);
      KIND_SW:   word = i_type(OP_SW, rs, rt, imm);
      KIND_BEQ:  word = i_type(OP_BEQ, rs, rt, imm);
      KIND_ORI:  word = i_type(OP_ORI, rs, rt, imm);
      KIND_LUI:  word = i_type(OP_LUI, 5'b0, rt, imm);
      KIND_JAL:  word = {OP_JAL, target};
      default: begin
        word  = 32'h0000_0000;
        legal = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/instr_loader.sv
// Program-image writer: accepts symbolic instructions on a valid/ready port, encodes them and
// writes them into instruction memory at consecutive word addresses starting at BASE_ADDR.
module instr_loader
  import mips_isa_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_3000,
  parameter int          DEPTH     = 1024,
  parameter int          CNT_W     = 11
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             finish,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_kind,
  input  logic [4:0]       in_rs,
  input  logic [4:0]       in_rt,
  input  logic [4:0]       in_rd,
  input  logic [15:0]      in_imm,
  input  logic [25:0]      in_target,
  output logic             im_we,
  output logic [31:0]      im_addr,
  output logic [31:0]      im_wdata,
  output logic [CNT_W-1:0] count,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  state_t      state;
  state_t      state_next;
  logic [31:0] enc_word;
  logic        enc_legal;
  logic        accept;
  logic        write_beat;
  logic        restart;

  instr_encode u_encode (
    .kind   (in_kind),
    .rs     (in_rs),
    .rt     (in_rt),
    .rd     (in_rd),
    .imm    (in_imm),
    .target (in_target),
    .word   (enc_word),
    .legal  (enc_legal)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (start)  state_next = ST_LOAD;
      ST_LOAD: if (finish) state_next = ST_DONE;
      ST_DONE: if (start)  state_next = ST_LOAD;
      default:             state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    busy     = (state == ST_LOAD);
    done     = (state == ST_DONE);
    in_ready = (state == ST_LOAD) && (count < FULL);
  end

  // Illegal beats still complete the handshake but only flag err; start inside LOAD is ignored.
  assign accept     = in_valid && in_ready;
  assign write_beat = accept && enc_legal;
  assign restart    = start && (state != ST_LOAD);

  always_ff @(posedge clk) begin
    if (reset) begin
      im_we    <= 1'b0;
      im_addr  <= BASE_ADDR;
      im_wdata <= 32'h0000_0000;
      count    <= '0;
      err      <= 1'b0;
    end else begin
      im_we <= write_beat;
      if (write_beat) begin
        im_addr  <= BASE_ADDR + (32'(count) << 2);
        im_wdata <= enc_word;
      end
      if (restart) begin
        count <= '0;
        err   <= 1'b0;
      end else begin
        if (write_beat)            count <= count + CNT_W'(1);
        if (accept && !enc_legal)  err   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_instr_loader.sv
// Directed bench for instr_loader: a vector table of encoded beats plus hand-written
// sequences for finish/start/reset/full corner cases.
module tb_instr_loader;

  localparam int CNT_W = 11;
  localparam int DEPTH = 1024;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic             finish;
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       in_kind;
  logic [4:0]       in_rs;
  logic [4:0]       in_rt;
  logic [4:0]       in_rd;
  logic [15:0]      in_imm;
  logic [25:0]      in_target;
  logic             im_we;
  logic [31:0]      im_addr;
  logic [31:0]      im_wdata;
  logic [CNT_W-1:0] count;
  logic             busy;
  logic             done;
  logic             err;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        valid;
    logic [3:0]  kind;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [15:0] imm;
    logic [25:0] target;
    logic        exp_we;
    logic [31:0] exp_wdata;
    logic [31:0] exp_addr;
    int          exp_count;
    logic        exp_err;
  } vec_t;

  vec_t vecs[15];

  instr_loader dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .finish    (finish),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_kind   (in_kind),
    .in_rs     (in_rs),
    .in_rt     (in_rt),
    .in_rd     (in_rd),
    .in_imm    (in_imm),
    .in_target (in_target),
    .im_we     (im_we),
    .im_addr   (im_addr),
    .im_wdata  (im_wdata),
    .count     (count),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic v, input logic [3:0] k, input logic [4:0] rs,
                              input logic [4:0] rt, input logic [4:0] rd, input logic [15:0] imm,
                              input logic [25:0] tgt, input logic we, input logic [31:0] wd,
                              input logic [31:0] ad, input int cnt, input logic e);
    vec_t r;
    r.valid = v; r.kind = k; r.rs = rs; r.rt = rt; r.rd = rd; r.imm = imm; r.target = tgt;
    r.exp_we = we; r.exp_wdata = wd; r.exp_addr = ad; r.exp_count = cnt; r.exp_err = e;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [3:0] k, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [15:0] imm, input logic [25:0] tgt);
    in_valid = v; in_kind = k; in_rs = rs; in_rt = rt; in_rd = rd; in_imm = imm; in_target = tgt;
  endtask

  task automatic applyStimulus(input vec_t v);
    drive(v.valid, v.kind, v.rs, v.rt, v.rd, v.imm, v.target);
    tick();
  endtask

  task automatic checkOutput(input string tag, input vec_t v);
    chk({tag, ".we"}, 32'(im_we), 32'(v.exp_we));
    if (v.exp_we) begin
      chk({tag, ".wdata"}, im_wdata, v.exp_wdata);
      chk({tag, ".addr"}, im_addr, v.exp_addr);
    end
    chk({tag, ".count"}, 32'(count), 32'(v.exp_count));
    chk({tag, ".err"}, 32'(err), 32'(v.exp_err));
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Table beats with junk in unused fields to prove they are zeroed.
    vecs[0]  = mk(1, 4'd7,  5'd0,  5'd1,  5'd0, 16'h1234, 26'h0,      1, 32'h3401_1234, 32'h3000, 1,  0);
    vecs[1]  = mk(1, 4'd1,  5'd1,  5'd2,  5'd3, 16'hFFFF, 26'h0,      1, 32'h0022_1820, 32'h3004, 2,  0);
    vecs[2]  = mk(1, 4'd6,  5'd7,  5'd2,  5'd0, 16'hABCD, 26'h0,      1, 32'h3C02_ABCD, 32'h3008, 3,  0);
    vecs[3]  = mk(1, 4'd8,  5'd3,  5'd4,  5'd0, 16'h0,    26'h0000C00, 1, 32'h0C00_0C00, 32'h300C, 4,  0);
    vecs[4]  = mk(1, 4'd5,  5'd1,  5'd2,  5'd0, 16'hFFFF, 26'h0,      1, 32'h1022_FFFF, 32'h3010, 5,  0);
    vecs[5]  = mk(1, 4'd4,  5'd0,  5'd2,  5'd0, 16'h0004, 26'h0,      1, 32'hAC02_0004, 32'h3014, 6,  0);
    vecs[6]  = mk(1, 4'd3,  5'd4,  5'd5,  5'd0, 16'h0008, 26'h0,      1, 32'h8C85_0008, 32'h3018, 7,  0);
    vecs[7]  = mk(1, 4'd2,  5'd7,  5'd8,  5'd9, 16'h0,    26'h0,      1, 32'h00E8_4822, 32'h301C, 8,  0);
    vecs[8]  = mk(1, 4'd10, 5'd10, 5'd11, 5'd12, 16'h0,   26'h0,      1, 32'h014B_6026, 32'h3020, 9,  0);
    vecs[9]  = mk(1, 4'd9,  5'd31, 5'd5,  5'd6, 16'hFFFF, 26'h0,      1, 32'h03E0_0008, 32'h3024, 10, 0);
    vecs[10] = mk(1, 4'd0,  5'd1,  5'd2,  5'd3, 16'h1111, 26'h12345,  1, 32'h0000_0000, 32'h3028, 11, 0);
    vecs[11] = mk(1, 4'd13, 5'd1,  5'd1,  5'd1, 16'h0,    26'h0,      0, 32'h0,         32'h0,    11, 1);
    vecs[12] = mk(1, 4'd7,  5'd2,  5'd3,  5'd0, 16'h00FF, 26'h0,      1, 32'h3443_00FF, 32'h302C, 12, 1);
    vecs[13] = mk(0, 4'd7,  5'd2,  5'd3,  5'd0, 16'h00FF, 26'h0,      0, 32'h0,         32'h0,    12, 1);
    vecs[14] = mk(1, 4'd11, 5'd0,  5'd0,  5'd0, 16'h0,    26'h0,      0, 32'h0,         32'h0,    12, 1);

    reset = 1; start = 0; finish = 0;
    drive(0, 4'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0);
    tick(); tick();
    reset = 0;
    chk("rst.we", 32'(im_we), 32'd0);
    chk("rst.addr", im_addr, 32'h3000);
    chk("rst.wdata", im_wdata, 32'h0);
    chk("rst.count", 32'(count), 32'd0);
    chk("rst.err", 32'(err), 32'd0);
    chk("rst.ready", 32'(in_ready), 32'd0);
    chk("rst.busy", 32'(busy), 32'd0);

    // A beat offered in IDLE must be refused.
    drive(1, 4'd7, 5'd0, 5'd1, 5'd0, 16'h1234, 26'h0);
    tick();
    chk("idle.we", 32'(im_we), 32'd0);
    chk("idle.count", 32'(count), 32'd0);

    drive(0, 4'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0);
    start = 1; tick(); start = 0;
    chk("start.busy", 32'(busy), 32'd1);
    chk("start.ready", 32'(in_ready), 32'd1);

    for (int i = 0; i < 15; i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("vec%0d", i), vecs[i]);
    end

    // Start inside LOAD is ignored; finish together with a beat still writes it.
    start = 1;
    drive(1, 4'd7, 5'd0, 5'd1, 5'd0, 16'h1234, 26'h0);
    finish = 1; tick(); finish = 0; start = 0;
    drive(0, 4'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0);
    chk("fin.we", 32'(im_we), 32'd1);
    chk("fin.addr", im_addr, 32'h3030);
    chk("fin.count", 32'(count), 32'd13);
    chk("fin.done", 32'(done), 32'd1);
    chk("fin.busy", 32'(busy), 32'd0);
    tick();
    chk("fin.we_drop", 32'(im_we), 32'd0);

    start = 1; tick(); start = 0;
    chk("restart.count", 32'(count), 32'd0);
    chk("restart.err", 32'(err), 32'd0);
    chk("restart.busy", 32'(busy), 32'd1);
    drive(1, 4'd1, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
    tick();
    chk("restart.addr", im_addr, 32'h3000);
    chk("restart.wdata", im_wdata, 32'h0022_1820);
    drive(1, 4'd15, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0);
    tick();
    chk("restart.err_set", 32'(err), 32'd1);
    drive(1, 4'd6, 5'd0, 5'd2, 5'd0, 16'hABCD, 26'h0);
    tick();

    // Reset while a beat is still being offered.
    reset = 1; tick(); reset = 0;
    drive(0, 4'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0);
    chk("midrst.we", 32'(im_we), 32'd0);
    chk("midrst.count", 32'(count), 32'd0);
    chk("midrst.err", 32'(err), 32'd0);
    chk("midrst.busy", 32'(busy), 32'd0);
    start = 1; tick(); start = 0;
    drive(1, 4'd1, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
    tick();
    chk("midrst.addr", im_addr, 32'h3000);
    chk("midrst.wdata", im_wdata, 32'h0022_1820);
    chk("midrst.err2", 32'(err), 32'd0);

    // Fill to DEPTH with in_valid held high.
    reset = 1; tick(); reset = 0;
    start = 1; tick(); start = 0;
    for (int i = 0; i < DEPTH; i++) begin
      drive(1, 4'd7, 5'd0, 5'd1, 5'd0, 16'(i), 26'h0);
      tick();
    end
    chk("full.count", 32'(count), 32'(DEPTH));
    chk("full.last_addr", im_addr, 32'h3FFC);
    chk("full.last_wdata", im_wdata, 32'h3401_03FF);
    chk("full.ready", 32'(in_ready), 32'd0);
    tick();
    chk("full.we", 32'(im_we), 32'd0);
    chk("full.count_hold", 32'(count), 32'(DEPTH));
    drive(0, 4'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0);
    finish = 1; tick(); finish = 0;
    chk("full.done", 32'(done), 32'd1);
    chk("full.count_sat", 32'(count), 32'(DEPTH));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
